// File: rtl/mem_access.sv
// rtl/mem_access.sv - memory stage: stalls EM on data-memory accesses, formats load/store data, flags misalignment and bus timeout
module mem_access #(
  parameter int DMEM_TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rstd,
  input  logic [31:0] EM_pc,
  input  logic [31:0] EM_alu_result,
  input  logic [31:0] EM_w_data,
  input  logic [1:0]  EM_mem_access_width,
  input  logic [4:0]  EM_rd_addr,
  input  logic        EM_w_enable,
  input  logic        EM_is_store,
  input  logic        EM_is_load,
  input  logic        EM_is_load_unsigned,
  output logic        mem_stall,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [3:0]  dmem_wstrb,
  output logic [31:0] dmem_wdata,
  input  logic [31:0] dmem_rdata,
  input  logic        dmem_ack,
  output logic [31:0] MW_pc,
  output logic [4:0]  MW_rd_addr,
  output logic        MW_w_enable,
  output logic [31:0] MW_w_data,
  output logic        mem_misaligned,
  output logic        mem_fault
);

  localparam int CW = $clog2(DMEM_TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, ACCESS, FAULT} state_t;

  state_t         state_q, state_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [31:0]    addr_q, addr_d, sdata_q, sdata_d, pc_q, pc_d;
  logic [1:0]     width_q, width_d;
  logic [4:0]     rd_q, rd_d;
  logic           uns_q, uns_d, store_q, store_d, wen_q, wen_d;
  logic [31:0]    mw_pc_q, mw_pc_d, mw_data_q, mw_data_d;
  logic [4:0]     mw_rd_q, mw_rd_d;
  logic           mw_wen_q, mw_wen_d, mis_q, mis_d;
  logic           stall_c;

  logic           em_mem, em_mis, in_acc;
  logic [7:0]     rd_byte;
  logic [15:0]    rd_half;
  logic [31:0]    load_val;
  logic [3:0]     strb;
  logic [31:0]    wrep;

  assign em_mem = EM_is_load | EM_is_store;
  assign em_mis = ((EM_mem_access_width == 2'd1) && EM_alu_result[0]) ||
                  (EM_mem_access_width[1] && (EM_alu_result[1:0] != 2'b00));
  assign in_acc = (state_q == ACCESS);

  // Load data: pick the addressed lane of the returned word and extend it
  always_comb begin
    rd_byte  = 8'h00;
    rd_half  = addr_q[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];
    load_val = dmem_rdata;
    case (addr_q[1:0])
      2'd0:    rd_byte = dmem_rdata[7:0];
      2'd1:    rd_byte = dmem_rdata[15:8];
      2'd2:    rd_byte = dmem_rdata[23:16];
      default: rd_byte = dmem_rdata[31:24];
    endcase
    case (width_q)
      2'd0:    load_val = {{24{~uns_q & rd_byte[7]}}, rd_byte};
      2'd1:    load_val = {{16{~uns_q & rd_half[15]}}, rd_half};
      default: load_val = dmem_rdata;
    endcase
  end

  // Store lane enables and lane-replicated write data
  always_comb begin
    strb = 4'hF;
    wrep = sdata_q;
    case (width_q)
      2'd0: begin
        strb = 4'b0001 << addr_q[1:0];
        wrep = {4{sdata_q[7:0]}};
      end
      2'd1: begin
        strb = 4'b0011 << {addr_q[1], 1'b0};
        wrep = {2{sdata_q[15:0]}};
      end
      default: begin
        strb = 4'hF;
        wrep = sdata_q;
      end
    endcase
  end

  assign dmem_req   = in_acc;
  assign dmem_we    = in_acc & store_q;
  assign dmem_addr  = in_acc ? {addr_q[31:2], 2'b00} : 32'h0;
  assign dmem_wstrb = (in_acc & store_q) ? strb : 4'h0;
  assign dmem_wdata = (in_acc & store_q) ? wrep : 32'h0;

  assign mem_stall      = rstd & stall_c;
  assign mem_fault      = (state_q == FAULT);
  assign MW_pc          = mw_pc_q;
  assign MW_rd_addr     = mw_rd_q;
  assign MW_w_enable    = mw_wen_q;
  assign MW_w_data      = mw_data_q;
  assign mem_misaligned = mis_q;

  // Next state, latched transaction fields and writeback fields
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    addr_d    = addr_q;
    sdata_d   = sdata_q;
    pc_d      = pc_q;
    width_d   = width_q;
    rd_d      = rd_q;
    uns_d     = uns_q;
    store_d   = store_q;
    wen_d     = wen_q;
    mw_pc_d   = mw_pc_q;
    mw_rd_d   = mw_rd_q;
    mw_wen_d  = mw_wen_q;
    mw_data_d = mw_data_q;
    mis_d     = 1'b0;
    stall_c   = 1'b0;
    case (state_q)
      IDLE: begin
        if (!em_mem) begin
          mw_pc_d   = EM_pc;
          mw_rd_d   = EM_rd_addr;
          mw_wen_d  = EM_w_enable;
          mw_data_d = EM_alu_result;
        end else if (em_mis) begin
          mw_wen_d = 1'b0;
          mis_d    = 1'b1;
        end else begin
          stall_c  = 1'b1;
          addr_d   = EM_alu_result;
          sdata_d  = EM_w_data;
          pc_d     = EM_pc;
          width_d  = EM_mem_access_width;
          rd_d     = EM_rd_addr;
          uns_d    = EM_is_load_unsigned;
          store_d  = EM_is_store;
          // a load+store combination is treated as a store that never writes back
          wen_d    = EM_w_enable & ~(EM_is_load & EM_is_store);
          mw_wen_d = 1'b0;
          cnt_d    = '0;
          state_d  = ACCESS;
        end
      end
      ACCESS: begin
        if (dmem_ack) begin
          mw_pc_d   = pc_q;
          mw_rd_d   = rd_q;
          mw_wen_d  = wen_q;
          mw_data_d = store_q ? addr_q : load_val;
          state_d   = IDLE;
        end else begin
          stall_c  = 1'b1;
          mw_wen_d = 1'b0;
          if (cnt_q == CW'(DMEM_TIMEOUT - 1)) state_d = FAULT;
          else                                cnt_d   = cnt_q + CW'(1);
        end
      end
      default: begin
        stall_c  = 1'b1;
        mw_wen_d = 1'b0;
      end
    endcase
  end

  // State and data registers, cleared asynchronously by rstd
  always_ff @(posedge clk or negedge rstd) begin
    if (!rstd) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      addr_q    <= 32'h0;
      sdata_q   <= 32'h0;
      pc_q      <= 32'h0;
      width_q   <= 2'd0;
      rd_q      <= 5'd0;
      uns_q     <= 1'b0;
      store_q   <= 1'b0;
      wen_q     <= 1'b0;
      mw_pc_q   <= 32'h0;
      mw_rd_q   <= 5'd0;
      mw_wen_q  <= 1'b0;
      mw_data_q <= 32'h0;
      mis_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      addr_q    <= addr_d;
      sdata_q   <= sdata_d;
      pc_q      <= pc_d;
      width_q   <= width_d;
      rd_q      <= rd_d;
      uns_q     <= uns_d;
      store_q   <= store_d;
      wen_q     <= wen_d;
      mw_pc_q   <= mw_pc_d;
      mw_rd_q   <= mw_rd_d;
      mw_wen_q  <= mw_wen_d;
      mw_data_q <= mw_data_d;
      mis_q     <= mis_d;
    end
  end

endmodule

// File: tb/tb_mem_access.sv
// tb/tb_mem_access.sv - directed and randomized checks of mem_access against a behavioural model
module tb_mem_access;

  logic        clk = 1'b0;
  logic        rstd;
  logic [31:0] EM_pc, EM_alu_result, EM_w_data;
  logic [1:0]  EM_mem_access_width;
  logic [4:0]  EM_rd_addr;
  logic        EM_w_enable, EM_is_store, EM_is_load, EM_is_load_unsigned;
  logic        mem_stall, dmem_req, dmem_we;
  logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
  logic [3:0]  dmem_wstrb;
  logic        dmem_ack;
  logic [31:0] MW_pc, MW_w_data;
  logic [4:0]  MW_rd_addr;
  logic        MW_w_enable, mem_misaligned, mem_fault;

  int errors = 0;
  int checks = 0;

  mem_access #(.DMEM_TIMEOUT(4)) dut (
    .clk(clk), .rstd(rstd),
    .EM_pc(EM_pc), .EM_alu_result(EM_alu_result), .EM_w_data(EM_w_data),
    .EM_mem_access_width(EM_mem_access_width), .EM_rd_addr(EM_rd_addr),
    .EM_w_enable(EM_w_enable), .EM_is_store(EM_is_store), .EM_is_load(EM_is_load),
    .EM_is_load_unsigned(EM_is_load_unsigned),
    .mem_stall(mem_stall), .dmem_req(dmem_req), .dmem_we(dmem_we),
    .dmem_addr(dmem_addr), .dmem_wstrb(dmem_wstrb), .dmem_wdata(dmem_wdata),
    .dmem_rdata(dmem_rdata), .dmem_ack(dmem_ack),
    .MW_pc(MW_pc), .MW_rd_addr(MW_rd_addr), .MW_w_enable(MW_w_enable), .MW_w_data(MW_w_data),
    .mem_misaligned(mem_misaligned), .mem_fault(mem_fault)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic bit ref_misaligned(input logic [1:0] w, input logic [31:0] a);
    return (w == 2'd1 && (a % 2) != 0) || (w >= 2'd2 && (a % 4) != 0);
  endfunction

  function automatic logic [31:0] ref_load(input logic [1:0] w, input logic [31:0] a,
                                           input logic [31:0] rd, input bit uns);
    logic [31:0] v;
    logic [31:0] off;
    off = a % 4;
    if (w == 2'd0) begin
      v = (rd >> (8 * off)) % 256;
      if (!uns && v >= 128) v = v + 32'hFFFF_FF00;
    end else if (w == 2'd1) begin
      v = (rd >> (8 * (off / 2) * 2)) % 65536;
      if (!uns && v >= 32768) v = v + 32'hFFFF_0000;
    end else begin
      v = rd;
    end
    return v;
  endfunction

  function automatic logic [3:0] ref_strb(input logic [1:0] w, input logic [31:0] a);
    logic [31:0] off;
    off = a % 4;
    if (w == 2'd0)      return 4'(1 << off);
    else if (w == 2'd1) return (off >= 2) ? 4'd12 : 4'd3;
    else                return 4'd15;
  endfunction

  function automatic logic [31:0] ref_wdata(input logic [1:0] w, input logic [31:0] d);
    if (w == 2'd0)      return (d % 256) * 32'h0101_0101;
    else if (w == 2'd1) return (d % 65536) * 32'h0001_0001;
    else                return d;
  endfunction

  task automatic drive_nop();
    EM_is_load = 1'b0; EM_is_store = 1'b0; EM_w_enable = 1'b0;
    EM_is_load_unsigned = 1'b0; EM_mem_access_width = 2'd0;
    EM_pc = 32'h0; EM_rd_addr = 5'd0; EM_alu_result = 32'h0; EM_w_data = 32'h0;
  endtask

  // Entered and left at posedge+1; one EM operation from issue until writeback
  task automatic do_op(input bit ld, input bit st, input bit uns, input logic [1:0] w,
                       input logic [31:0] a, input logic [31:0] d, input logic [31:0] pc,
                       input logic [4:0] rd, input bit wen, input int waits,
                       input logic [31:0] rdata);
    EM_is_load = ld; EM_is_store = st; EM_is_load_unsigned = uns;
    EM_mem_access_width = w; EM_alu_result = a; EM_w_data = d;
    EM_pc = pc; EM_rd_addr = rd; EM_w_enable = wen;
    #1;
    if (!ld && !st) begin
      chk("alu_stall", mem_stall, 0);
      chk("alu_req", dmem_req, 0);
      @(posedge clk); #1;
      chk("alu_mw_pc", MW_pc, pc);
      chk("alu_mw_rd", MW_rd_addr, rd);
      chk("alu_mw_wen", MW_w_enable, wen);
      chk("alu_mw_data", MW_w_data, a);
    end else if (ref_misaligned(w, a)) begin
      chk("mis_stall", mem_stall, 0);
      chk("mis_req", dmem_req, 0);
      @(posedge clk); #1;
      chk("mis_pulse", mem_misaligned, 1);
      chk("mis_mw_wen", MW_w_enable, 0);
      drive_nop();
      @(posedge clk); #1;
      chk("mis_pulse_end", mem_misaligned, 0);
    end else begin
      chk("issue_stall", mem_stall, 1);
      chk("issue_req", dmem_req, 0);
      @(posedge clk); #1;
      chk("bubble_wen", MW_w_enable, 0);
      for (int k = 0; k <= waits; k++) begin
        #1;
        chk("acc_req", dmem_req, 1);
        chk("acc_addr", dmem_addr, a - (a % 4));
        chk("acc_we", dmem_we, st);
        if (st) begin
          chk("acc_wstrb", dmem_wstrb, ref_strb(w, a));
          chk("acc_wdata", dmem_wdata, ref_wdata(w, d));
        end
        if (k < waits) begin
          dmem_ack = 1'b0;
          dmem_rdata = $urandom;
          #1 chk("wait_stall", mem_stall, 1);
          @(posedge clk); #1;
          chk("wait_wen", MW_w_enable, 0);
        end else begin
          dmem_ack = 1'b1;
          dmem_rdata = rdata;
          #1 chk("ack_stall", mem_stall, 0);
          @(posedge clk); #1;
          dmem_ack = 1'b0;
          chk("done_mw_pc", MW_pc, pc);
          chk("done_mw_rd", MW_rd_addr, rd);
          chk("done_mw_wen", MW_w_enable, wen && !(ld && st));
          chk("done_mw_data", MW_w_data, st ? a : ref_load(w, a, rdata, uns));
          drive_nop();
          #1 chk("after_req", dmem_req, 0);
        end
      end
    end
  endtask

  initial begin
    logic [31:0] ra;
    logic [1:0]  rw;
    int          kind;
    rstd = 1'b0; dmem_ack = 1'b0; dmem_rdata = 32'h0;
    drive_nop();
    EM_is_load = 1'b1; EM_alu_result = 32'h100; EM_mem_access_width = 2'd2;
    #2;
    chk("rst_stall", mem_stall, 0);
    chk("rst_req", dmem_req, 0);
    chk("rst_mw_wen", MW_w_enable, 0);
    chk("rst_mw_data", MW_w_data, 0);
    chk("rst_fault", mem_fault, 0);
    chk("rst_wstrb", dmem_wstrb, 0);
    @(posedge clk); #1;
    rstd = 1'b1;
    drive_nop();
    @(posedge clk); #1;

    do_op(0, 0, 0, 2'd0, 32'h1234, 32'h0, 32'h40, 5'd5, 1, 0, 32'h0);
    do_op(1, 0, 0, 2'd0, 32'h103, 32'h0, 32'h44, 5'd6, 1, 3, 32'h80FF_0000);
    do_op(1, 0, 1, 2'd0, 32'h103, 32'h0, 32'h48, 5'd7, 1, 3, 32'h80FF_0000);
    do_op(0, 1, 0, 2'd1, 32'h102, 32'hABCD_1234, 32'h4C, 5'd0, 0, 1, 32'h0);
    do_op(1, 0, 0, 2'd2, 32'h2, 32'h0, 32'h50, 5'd8, 1, 0, 32'h0);
    do_op(1, 1, 0, 2'd2, 32'h200, 32'h5555_AAAA, 32'h54, 5'd9, 1, 0, 32'h0);
    do_op(1, 0, 0, 2'd1, 32'h302, 32'h0, 32'h58, 5'd10, 1, 2, 32'h8001_7FFF);

    for (int i = 0; i < 40; i++) begin
      kind = $urandom_range(0, 2);
      rw   = 2'($urandom_range(0, 3));
      ra   = $urandom_range(0, 32'hFFFF);
      do_op(kind == 1, kind == 2, 1'($urandom), rw, ra, $urandom, $urandom,
            5'($urandom), 1'($urandom), $urandom_range(0, 3), $urandom);
    end

    EM_is_load = 1'b1; EM_mem_access_width = 2'd2; EM_alu_result = 32'h40;
    EM_w_enable = 1'b1; EM_rd_addr = 5'd3;
    @(posedge clk); #1;
    for (int k = 0; k < 4; k++) begin
      #1 chk("to_req", dmem_req, 1);
      chk("to_stall", mem_stall, 1);
      @(posedge clk); #1;
    end
    dmem_ack = 1'b1;
    #1;
    chk("fault_flag", mem_fault, 1);
    chk("fault_stall", mem_stall, 1);
    chk("fault_req", dmem_req, 0);
    @(posedge clk); #1;
    dmem_ack = 1'b0;
    chk("fault_sticky", mem_fault, 1);
    chk("fault_mw_wen", MW_w_enable, 0);
    rstd = 1'b0;
    #1;
    chk("frst_fault", mem_fault, 0);
    chk("frst_stall", mem_stall, 0);
    chk("frst_req", dmem_req, 0);
    chk("frst_addr", dmem_addr, 0);
    chk("frst_mw_pc", MW_pc, 0);
    rstd = 1'b1;
    drive_nop();
    @(posedge clk); #1;

    EM_is_load = 1'b1; EM_mem_access_width = 2'd2; EM_alu_result = 32'h80;
    EM_w_enable = 1'b1; EM_rd_addr = 5'd4; EM_pc = 32'h4444;
    @(posedge clk); #1;
    chk("mid_req", dmem_req, 1);
    rstd = 1'b0;
    #1;
    chk("mid_rst_req", dmem_req, 0);
    chk("mid_rst_stall", mem_stall, 0);
    EM_is_load = 1'b0; EM_pc = 32'h500; EM_rd_addr = 5'd7; EM_alu_result = 32'hCAFE;
    EM_w_enable = 1'b1;
    @(posedge clk); #1;
    rstd = 1'b1;
    #1;
    chk("rel_req", dmem_req, 0);
    chk("rel_stall", mem_stall, 0);
    chk("rel_mw_wen", MW_w_enable, 0);
    @(posedge clk); #1;
    chk("rel_mw_pc", MW_pc, 32'h500);
    chk("rel_mw_rd", MW_rd_addr, 7);
    chk("rel_mw_data", MW_w_data, 32'hCAFE);
    chk("rel_mw_wen1", MW_w_enable, 1);
    chk("rel_req2", dmem_req, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mem_access.md
MEM_ACCESS -- requirements
Module: mem_access

Interface
REQ-001 Parameter DMEM_TIMEOUT, default 16: maximum cycles in ACCESS without dmem_ack before fault.
REQ-002 clk  in  1  clock; all flops on posedge.
REQ-003 rstd  in  1  reset, asynchronous, active-low.
REQ-004 EM_pc  in  32  pc of instruction in EM register.
REQ-005 EM_alu_result  in  32  ALU result; byte address for load/store.
REQ-006 EM_w_data  in  32  store data (rs2).
REQ-007 EM_mem_access_width  in  2  0=byte, 1=half, 2=word, 3=word.
REQ-008 EM_rd_addr / EM_w_enable / EM_is_store / EM_is_load / EM_is_load_unsigned  in  5/1/1/1/1  EM control fields.
REQ-009 mem_stall  out  1  hold EM register and all upstream stages.
REQ-010 dmem_req / dmem_we  out  1/1  request valid; 1=write.
REQ-011 dmem_addr  out  32  word address, bits[1:0]=0.
REQ-012 dmem_wstrb / dmem_wdata  out  4/32  byte lane enables; lane-replicated store data.
REQ-013 dmem_rdata / dmem_ack  in  32/1  read word; one-cycle completion pulse.
REQ-014 MW_pc / MW_rd_addr / MW_w_enable / MW_w_data  out  32/5/1/32  registered writeback fields.
REQ-015 mem_misaligned  out  1  registered one-cycle pulse per dropped misaligned access.
REQ-016 mem_fault  out  1  sticky timeout flag.

Function
REQ-017 FSM states IDLE, ACCESS, FAULT; reset state IDLE.
REQ-018 IDLE, non-memory op (EM_is_load=EM_is_store=0): next edge MW_pc<=EM_pc, MW_rd_addr<=EM_rd_addr, MW_w_enable<=EM_w_enable, MW_w_data<=EM_alu_result; latency 1; mem_stall=0.
REQ-019 Misalignment: half with addr[0]=1, or word (width 2/3) with addr[1:0]!=0.
REQ-020 IDLE, misaligned memory op: no request, no stall; next edge MW_w_enable<=0, mem_misaligned<=1 for exactly one cycle.
REQ-021 IDLE, aligned memory op: mem_stall=1 combinationally; latch address, width, store data, unsigned flag, pc, rd_addr, w_enable; MW_w_enable<=0 (bubble); next state ACCESS.
REQ-022 EM_is_load and EM_is_store both 1: handled as store; MW_w_enable forced 0.
REQ-023 ACCESS: dmem_req=1 and dmem_addr/we/wstrb/wdata driven from latched values, stable until ack; mem_stall=1 except in the dmem_ack cycle.
REQ-024 ACCESS with dmem_ack=1: mem_stall=0 that cycle; next edge MW_* loaded from latched fields, state IDLE; no request in the following cycle unless a new op is in EM.
REQ-025 ACCESS without dmem_ack: MW_w_enable<=0 each cycle.
REQ-026 Load MW_w_data: select byte addr[1:0] / halfword addr[1] of dmem_rdata; zero-extend if unsigned else sign-extend; word unmodified.
REQ-027 Store strobes: byte 4'b0001<<addr[1:0]; half 4'b0011<<{addr[1],1'b0}; word 4'hF; wdata byte replicated x4, half replicated x2.
REQ-028 Store completion: MW_w_data<=latched address, MW_w_enable<=latched EM_w_enable.
REQ-029 Timeout counter cleared on ACCESS entry, +1 per ACCESS cycle without ack; ack in the cycle count reaches DMEM_TIMEOUT-1 still completes; otherwise next state FAULT.
REQ-030 FAULT: mem_fault=1, mem_stall=1, dmem_req=0, MW_w_enable=0; exit only by reset.
REQ-031 dmem_ack outside ACCESS ignored.

Reset
REQ-032 rstd=0 asynchronously forces IDLE, counter 0, all MW_* 0, mem_misaligned=0, mem_fault=0, dmem_req=0, dmem_we=0, dmem_wstrb=0, dmem_addr=0, dmem_wdata=0; mem_stall=0 while in reset.
REQ-033 Reset during ACCESS aborts the transaction; no MW write from it after release.

Verification
REQ-034 ALU op EM_alu_result=0x1234, rd=5, w_enable=1 -> next cycle MW_w_data=0x1234, MW_rd_addr=5, MW_w_enable=1, no dmem_req.
REQ-035 Signed byte load addr 0x103, ack after 3 wait cycles, rdata=0x80FF_0000 -> stall 4 cycles, MW_w_data=0xFFFF_FF80; unsigned same -> 0x0000_0080.
REQ-036 Half store addr 0x102, data 0xABCD_1234 -> dmem_addr=0x100, wstrb=4'b1100, wdata=0x1234_1234, dmem_we=1.
REQ-037 Word load addr 0x2 -> mem_misaligned one pulse, no dmem_req, MW_w_enable=0, no stall.
REQ-038 DMEM_TIMEOUT=4, no ack -> FAULT after 4 ACCESS cycles, mem_fault=1, stall held; rstd low -> all outputs 0.
REQ-039 rstd low mid-ACCESS, then release with non-memory op in EM -> IDLE, dmem_req=0, normal 1-cycle ALU passthrough.
